// File: rtl/cp0_intc.sv
// Multi-source CP0 interrupt controller: edge-latched pending lines, mask and priority,
// EPC save, per-source vectored redirect and eret return.
module cp0_intc_line (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pend
);
    logic irq_q;

    // A rising edge sets pending. If a clear arrives in the same cycle, the set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            irq_q <= irq;
            if (irq && !irq_q) pend <= 1'b1;
            else if (clr)      pend <= 1'b0;
        end
    end
endmodule

module cp0_intc #(
    parameter int          N_IRQ     = 8,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ir_en,
    input  logic [31:0]      ret_addr,
    input  logic             eret,
    input  logic [4:0]       cp_addr_r,
    output logic [31:0]      cp_data_r,
    input  logic             cp_wen,
    input  logic [4:0]       cp_addr_w,
    input  logic [31:0]      cp_data_w,
    output logic             jump_en,
    output logic [31:0]      jump_addr,
    output logic             stall,
    output logic [31:0]      EPCR
);
    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RETURN} state_t;

    state_t           state, state_nxt;
    logic             ie;
    logic [N_IRQ-1:0] mask, pend, elig, clr;
    logic [4:0]       cause_id, win_id;
    logic [31:0]      epc, vec_q, win_vec;
    logic             take, wr_status, wr_cause, wr_epc;

    assign wr_status = cp_wen && (cp_addr_w == A_STATUS);
    assign wr_cause  = cp_wen && (cp_addr_w == A_CAUSE);
    assign wr_epc    = cp_wen && (cp_addr_w == A_EPC);

    assign elig = pend & mask;
    assign take = (state == S_IDLE) && !eret && ie && ir_en && (|elig);

    // Scan downwards so the lowest set index is the last one assigned.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (elig[i]) win_id = 5'(i);
    end
    assign win_vec = VEC_BASE + (32'(win_id) << VEC_SHIFT);

    always_comb begin
        for (int i = 0; i < N_IRQ; i++)
            clr[i] = ((state == S_ENTER) && (cause_id == 5'(i))) || (wr_cause && cp_data_w[8+i]);
    end

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        cp0_intc_line u_line (
            .clk  (clk),
            .rst  (rst),
            .irq  (irq_in[g]),
            .clr  (clr[g]),
            .pend (pend[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        jump_en   = 1'b0;
        stall     = 1'b0;
        jump_addr = '0;
        case (state)
            S_IDLE: begin
                if (eret)      state_nxt = S_RETURN;
                else if (take) state_nxt = S_ENTER;
            end
            S_ENTER: begin
                jump_en   = 1'b1;
                stall     = 1'b1;
                jump_addr = vec_q;
                state_nxt = S_IDLE;
            end
            S_RETURN: begin
                jump_en   = 1'b1;
                stall     = 1'b1;
                jump_addr = epc;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Hardware updates of IE and EPC take precedence over a same-cycle mtc0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie       <= 1'b0;
            mask     <= '0;
            epc      <= '0;
            cause_id <= '0;
            vec_q    <= '0;
        end else begin
            if (take)                  ie <= 1'b0;
            else if (state == S_RETURN) ie <= 1'b1;
            else if (wr_status)        ie <= cp_data_w[0];

            if (wr_status) mask <= cp_data_w[8 +: N_IRQ];

            if (take)        epc <= ret_addr;
            else if (wr_epc) epc <= cp_data_w;

            if (take) begin
                cause_id <= win_id;
                vec_q    <= win_vec;
            end
        end
    end

    always_comb begin
        cp_data_r = '0;
        case (cp_addr_r)
            A_STATUS: begin
                cp_data_r[0]          = ie;
                cp_data_r[8 +: N_IRQ] = mask;
            end
            A_CAUSE: begin
                cp_data_r[6:2]        = cause_id;
                cp_data_r[8 +: N_IRQ] = pend;
            end
            A_EPC:   cp_data_r = epc;
            default: cp_data_r = '0;
        endcase
    end

    assign EPCR = epc;
endmodule
